// File: rtl/usb_pkg.sv
// Shared USB link definitions used by the
// NRZI encoder and decoder sides.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    EOP1,
    EOP2
  } state_t;

  localparam int SYNC_ZEROS = 7;

  localparam logic J = 1'b1;
  localparam logic K = 1'b0;

  localparam int CNT_W = 7;
  localparam int MAX_PKT_BITS = 104;

endpackage

// File: rtl/nrzi_dec_ctrl.sv
// Decoder control: SYNC tracking, payload
// counting and EOP framing.
module nrzi_dec_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_BITS = MAX_PKT_BITS
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             valid,
  input  logic             se0,
  input  logic             raw,
  input  logic             level,
  output logic             emit,
  output logic             first,
  output logic             done,
  output logic             err,
  output logic             to_idle,
  output logic [CNT_W-1:0] count
);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       zeros;
  logic [2:0]       zeros_nxt;
  logic [CNT_W-1:0] count_nxt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      zeros <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      zeros <= zeros_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    zeros_nxt = zeros;
    count_nxt = count;
    emit      = 1'b0;
    first     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (valid) begin
      unique case (state)
        IDLE: begin
          if (!se0 && !raw) begin
            state_nxt = SYNC;
            zeros_nxt = 3'd1;
          end
        end
        SYNC: begin
          if (se0) begin
            err = 1'b1;
          end else if (raw) begin
            if (zeros == 3'(SYNC_ZEROS)) begin
              state_nxt = PAYLOAD;
              count_nxt = '0;
            end else begin
              err = 1'b1;
            end
          end else if (zeros == 3'(SYNC_ZEROS)) begin
            err = 1'b1;
          end else begin
            zeros_nxt = zeros + 3'd1;
          end
        end
        PAYLOAD: begin
          if (se0) begin
            if (count == '0) err = 1'b1;
            else state_nxt = EOP1;
          end else if (count == CNT_W'(MAX_BITS)) begin
            err = 1'b1;
          end else begin
            emit      = 1'b1;
            first     = (count == '0);
            count_nxt = count + 1'b1;
          end
        end
        EOP1: begin
          if (se0) state_nxt = EOP2;
          else err = 1'b1;
        end
        EOP2: begin
          if (!se0 && level == J) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            err = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (err) state_nxt = IDLE;
    end
    to_idle = valid && (state_nxt == IDLE);
  end

endmodule

// File: rtl/nrzi_dec.sv
// USB receive NRZI decoder: line level to raw
// payload bits with packet framing.
module nrzi_dec
  import usb_pkg::*;
#(
  parameter int MAX_BITS = 104
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       line_bit,
  input  logic       line_se0,
  input  logic       line_valid,
  output logic       bstr_out,
  output logic       bstr_out_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic [6:0] bit_count,
  output logic       frame_err
);

  logic prev_level;
  logic raw;
  logic emit;
  logic first;
  logic done;
  logic err;
  logic to_idle;

  // No transition on the line decodes as a 1
  assign raw = (line_bit == prev_level);

  nrzi_dec_ctrl #(
    .MAX_BITS (MAX_BITS)
  ) u_ctrl (
    .clk     (clk),
    .rst_b   (rst_b),
    .valid   (line_valid),
    .se0     (line_se0),
    .raw     (raw),
    .level   (line_bit),
    .emit    (emit),
    .first   (first),
    .done    (done),
    .err     (err),
    .to_idle (to_idle),
    .count   (bit_count)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev_level <= J;
    end else if (line_valid) begin
      if (to_idle) prev_level <= J;
      else if (!line_se0) prev_level <= line_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bstr_out       <= 1'b0;
      bstr_out_valid <= 1'b0;
      pkt_start      <= 1'b0;
      pkt_end        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      bstr_out       <= emit & raw;
      bstr_out_valid <= emit;
      pkt_start      <= first;
      pkt_end        <= done;
      frame_err      <= err;
    end
  end

endmodule

// File: tb/tb_nrzi_dec.sv
// Randomized packet-level bench for nrzi_dec
// against a packet-construction reference.
module tb_nrzi_dec;

  localparam int MAX_BITS = 104;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       line_bit = 1'b1;
  logic       line_se0 = 1'b0;
  logic       line_valid = 1'b0;
  logic       bstr_out;
  logic       bstr_out_valid;
  logic       pkt_start;
  logic       pkt_end;
  logic [6:0] bit_count;
  logic       frame_err;

  always #5 clk = ~clk;

  nrzi_dec #(
    .MAX_BITS (MAX_BITS)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .line_bit       (line_bit),
    .line_se0       (line_se0),
    .line_valid     (line_valid),
    .bstr_out       (bstr_out),
    .bstr_out_valid (bstr_out_valid),
    .pkt_start      (pkt_start),
    .pkt_end        (pkt_end),
    .bit_count      (bit_count),
    .frame_err      (frame_err)
  );

  int n_tests = 0;
  int n_fail = 0;
  int samp = 0;

  bit got_q[$];
  bit pay[$];
  bit ack[$];
  int got_start;
  int got_end;
  int got_err;
  int start_pos;
  int ev_samp;
  int last_bit_samp;
  logic [6:0] exp_count = '0;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input bit q[$]);
    logic [127:0] v;
    v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_start     = 0;
    got_end       = 0;
    got_err       = 0;
    start_pos     = -1;
    ev_samp       = -1;
    last_bit_samp = -1;
  endtask

  task automatic send(bit v, bit se0, bit lb);
    line_valid = v;
    line_se0   = se0;
    line_bit   = lb;
    @(posedge clk);
    #1;
    if (v) samp++;
    else check("gap_pulse",
               {bstr_out_valid, pkt_start, pkt_end, frame_err},
               '0);
    if (bstr_out_valid) begin
      got_q.push_back(bstr_out);
      last_bit_samp = samp;
    end
    if (pkt_start) begin
      got_start++;
      start_pos = got_q.size();
    end
    if (pkt_end) begin
      got_end++;
      ev_samp = samp;
    end
    if (frame_err) begin
      got_err++;
      ev_samp = samp;
    end
  endtask

  task automatic put(bit se0, bit lb, int gap);
    if (gap == 1)
      send(1'b0, 1'($urandom), 1'($urandom));
    else if (gap == 2)
      repeat ($urandom_range(0, 2))
        send(1'b0, 1'($urandom), 1'($urandom));
    send(1'b1, se0, lb);
  endtask

  // sync_n raw zeros (then a raw 1 unless 8), payload from pay,
  // eop: 0 good, 1 SE0 K, 2 SE0 SE0 SE0, 3 SE0 SE0 K
  task automatic run_pkt(string name, int sync_n, int eop,
                         int gap);
    bit lvl;
    bit raw_q[$];
    bit exp_q[$];
    bit sync_ok;
    int n;
    int last;
    int exp_s;
    int exp_e;
    int exp_r;
    clear_mon();
    lvl     = 1'b1;
    sync_ok = (sync_n == 7);
    n       = pay.size();
    exp_s   = 0;
    exp_e   = 0;
    exp_r   = 0;
    for (int i = 0; i < sync_n; i++) raw_q.push_back(1'b0);
    if (sync_n < 8) raw_q.push_back(1'b1);
    if (!sync_ok) begin
      exp_r = 1;
    end else if (n == 0) begin
      exp_r     = 1;
      exp_count = '0;
    end else if (n > MAX_BITS) begin
      for (int i = 0; i < MAX_BITS; i++) exp_q.push_back(pay[i]);
      for (int i = 0; i <= MAX_BITS; i++) raw_q.push_back(pay[i]);
      exp_s     = 1;
      exp_r     = 1;
      exp_count = 7'(MAX_BITS);
    end else begin
      foreach (pay[i]) begin
        exp_q.push_back(pay[i]);
        raw_q.push_back(pay[i]);
      end
      exp_s     = 1;
      exp_e     = (eop == 0) ? 1 : 0;
      exp_r     = (eop == 0) ? 0 : 1;
      exp_count = 7'(n);
    end
    foreach (raw_q[i]) begin
      if (!raw_q[i]) lvl = ~lvl;
      put(1'b0, lvl, gap);
    end
    if (sync_ok && n == 0) begin
      put(1'b1, 1'b0, gap);
    end else if (sync_ok && n <= MAX_BITS) begin
      put(1'b1, 1'b0, gap);
      case (eop)
        0: begin put(1'b1, 1'b0, gap); put(1'b0, 1'b1, gap); end
        1: put(1'b0, 1'b0, gap);
        2: begin put(1'b1, 1'b0, gap); put(1'b1, 1'b0, gap); end
        default: begin put(1'b1, 1'b0, gap); put(1'b0, 1'b0, gap); end
      endcase
    end
    last = samp;
    repeat (3) put(1'b0, 1'b1, 0);
    check({name, ".nbits"}, got_q.size(), exp_q.size());
    check({name, ".bits"}, pack(got_q), pack(exp_q));
    check({name, ".start"}, got_start, exp_s);
    check({name, ".end"}, got_end, exp_e);
    check({name, ".err"}, got_err, exp_r);
    check({name, ".count"}, bit_count, exp_count);
    check({name, ".ev_samp"}, ev_samp, last);
    if (exp_s != 0) check({name, ".start_pos"}, start_pos, 1);
    if (exp_e != 0)
      check({name, ".end_lat"}, last - last_bit_samp, 3);
  endtask

  task automatic rand_pay(int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(1'($urandom));
  endtask

  initial begin
    bit lvl;
    ack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_outs",
          {bstr_out, bstr_out_valid, pkt_start, pkt_end, frame_err},
          '0);
    check("rst_count", bit_count, 0);
    rst_b = 1'b1;
    clear_mon();
    repeat (10) send(1'b1, 1'b0, 1'b1);
    check("idle_quiet",
          got_start + got_end + got_err + got_q.size(), 0);

    pay = ack;
    run_pkt("ack", 7, 0, 0);
    pay.delete();
    run_pkt("short_sync", 5, 0, 0);
    pay = ack;
    run_pkt("ack_after_short", 7, 0, 0);
    pay.delete();
    run_pkt("long_sync", 8, 0, 0);
    rand_pay(MAX_BITS + 1);
    run_pkt("overflow", 7, 0, 0);
    rand_pay(MAX_BITS);
    run_pkt("max_len", 7, 0, 0);
    pay.delete();
    run_pkt("empty", 7, 0, 0);
    pay = ack;
    run_pkt("eop_se0_k", 7, 1, 0);
    run_pkt("eop_3se0", 7, 2, 0);
    run_pkt("eop_se0se0_k", 7, 3, 0);
    run_pkt("ack_gaps", 7, 0, 1);

    clear_mon();
    lvl = 1'b1;
    for (int i = 0; i < 7; i++) begin
      lvl = ~lvl;
      send(1'b1, 1'b0, lvl);
    end
    send(1'b1, 1'b0, lvl);
    for (int i = 0; i < 4; i++) begin
      if (!ack[i]) lvl = ~lvl;
      send(1'b1, 1'b0, lvl);
    end
    check("midrst_pre_valid", bstr_out_valid, 1);
    line_valid = 1'b0;
    rst_b = 1'b0;
    #1;
    check("midrst_outs",
          {bstr_out, bstr_out_valid, pkt_start, pkt_end, frame_err},
          '0);
    check("midrst_count", bit_count, 0);
    exp_count = '0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    pay = ack;
    run_pkt("ack_after_rst", 7, 0, 0);

    for (int k = 0; k < 40; k++) begin
      int sn;
      int ln;
      int ek;
      sn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 7;
      ln = ($urandom_range(0, 7) == 0) ?
           $urandom_range(100, 106) : $urandom_range(1, 20);
      ek = ($urandom_range(0, 4) < 3) ? 0 : $urandom_range(1, 3);
      rand_pay(ln);
      run_pkt($sformatf("rnd%0d", k), sn, ek, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nrzi_dec.md
Name: nrzi_dec

Overview:
Receive-side NRZI decoder for the USB serial link; the inverse of the transmit-side NRZI encoder.
- Samples the line one bit per valid cycle and tracks the SYNC field.
- Decodes NRZI transitions back to raw bits and forwards the payload bits (PID onward) to the downstream bit unstuffer.
- Detects end-of-packet (SE0, SE0, J) and reports the packet boundary, the payload bit count and any framing errors.

Parameters:
MAX_BITS, 104, maximum payload bits (after SYNC, before EOP) accepted before an overflow error; must be ≤ 127.

Ports:
clk  input  1  system clock; one clock, all state updates on rising edge
rst_b  input  1  asynchronous active-low reset
line_bit  input  1  sampled differential line level, 1 = J, 0 = K; ignored when line_se0 = 1
line_se0  input  1  single-ended-zero on the line
line_valid  input  1  line sample valid this cycle; when 0, all state holds
bstr_out  output  1  decoded raw payload bit
bstr_out_valid  output  1  bstr_out valid this cycle
pkt_start  output  1  one-cycle pulse coincident with the first payload bit
pkt_end  output  1  one-cycle pulse on a good EOP
bit_count  output  7  payload bits received; stable from pkt_end until the next pkt_start
frame_err  output  1  one-cycle pulse on any SYNC, EOP or overflow error

Behaviour:
- Reset (async, rst_b = 0):
  - state = IDLE; prev_level = 1 (J idle).
  - All outputs 0; bit_count = 0.
- Decode rule: raw = (line_bit == prev_level).
  - prev_level <= line_bit on every valid non-SE0 sample.
  - prev_level <= 1 whenever IDLE is re-entered.
- Output timing: all outputs are registered, so there is 1 cycle of latency from the valid sample. Pulses last exactly one cycle.
- FSM (transitions only on line_valid = 1):
  - IDLE: SE0 or raw 1 → stay. Raw 0 → SYNC with zero_cnt = 1.
  - SYNC: raw 0 with zero_cnt < 7 → zero_cnt++. Raw 1 with zero_cnt = 7 → PAYLOAD, bit_count <= 0. Raw 1 with zero_cnt < 7, raw 0 with zero_cnt = 7, or SE0 → frame_err, IDLE.
  - PAYLOAD, non-SE0 sample:
    - bstr_out = raw, bstr_out_valid = 1, bit_count++.
    - pkt_start on the first such bit.
    - If bit_count would exceed MAX_BITS → frame_err, IDLE, no valid output for that bit.
  - PAYLOAD, SE0 sample: → EOP1; if bit_count = 0 → frame_err, IDLE.
  - EOP1: SE0 → EOP2. Non-SE0 → frame_err, IDLE.
  - EOP2: J (line_bit = 1, no SE0) → pkt_end, IDLE. K or SE0 → frame_err, IDLE.
- line_valid = 0 in any state: no transitions, no counter change, valid/pulse outputs 0.
- bit_count is a 7-bit counter; it never wraps because the overflow check fires first.
- Reset mid-packet: immediate abort, no pkt_end or frame_err pulse, reset values apply.
- Simultaneous events: only one line sample per cycle, so no conflicts; an error takes precedence over output of the same sample.
- Bit stuffing is NOT removed here; the unstuffer downstream handles it. bit_count includes stuffed bits.

Decomposition:
- Shared package usb_pkg: state enum (IDLE, SYNC, PAYLOAD, EOP1, EOP2), SYNC_ZEROS = 7, line-level constants J = 1 and K = 0, and packet-size constants shared with the encoder side.
- One sub-module is natural: nrzi_dec_ctrl (FSM plus zero and bit counters), with the decode/prev_level register and output registers in the top level. This mirrors the encoder's control split.

Test Plan:
- Reset → all outputs 0 and bit_count = 0. Release rst_b with line J idle for 10 cycles → no pulses.
- ACK packet. Line K J K J K J K K, then 1 1 0 1 1 0 0 0, then SE0 SE0 J → bstr_out = 0,1,0,0,1,0,1,1 (PID 0xD2 LSB first). pkt_start with the first bit, pkt_end 3 cycles after the last bit, bit_count = 8.
- Short SYNC. Line K J K J K K (raw 0 0 0 0 0 1) → frame_err pulse, no bstr_out_valid, return to IDLE. A following good ACK decodes correctly.
- Overflow with MAX_BITS = 104. Valid SYNC then 105 payload samples → 104 valid bits, then frame_err on the 105th, no pkt_end.
- Bad EOP. After ACK payload, line SE0 K → frame_err, no pkt_end. Also SE0 SE0 SE0 → frame_err.
- Gaps and reset mid-packet. ACK with line_valid = 0 inserted every other cycle → identical decoded bits and counts. Assert rst_b = 0 after 4 payload bits → outputs 0 immediately; next packet decodes normally.
